keypad_scanner: RTL and testbench

- Scans a 4x4 matrix keypad and is the input-side counterpart of the display digit-select logic.
- Drives one active-low column at a time, in the same one-cold rotation used for display digits, and samples four active-low row lines.
- Debounces across full scans and reports single key presses as an encoded key index with a one-cycle strobe.
- Feeds the servo setpoint / mode-select logic of the hand controller.

---
 rtl/keypad_scanner.sv | 126 ++++++++++++
 tb/tb_keypad_scanner.sv | 206 ++++++++++++++++++++
 2 files changed

// File: rtl/keypad_scanner.sv
// 4x4 matrix keypad scanner: one-cold column rotation, row sampling at the end of
// each column slot, whole-scan debounce, and a one-cycle strobe per accepted key.
module keypad_scanner #(
  parameter int SCAN_DIV       = 50000,
  parameter int DEBOUNCE_SCANS = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [3:0] row_in,
  output logic [3:0] col_out,
  output logic [3:0] key_code,
  output logic       key_valid,
  output logic       key_held
);

  localparam int DIV_W = $clog2(SCAN_DIV);
  localparam int CNT_W = $clog2(DEBOUNCE_SCANS + 1);
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(SCAN_DIV - 1);
  localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(DEBOUNCE_SCANS);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  // Scan results: 0..15 are key indices, plus two out-of-band codes.
  localparam logic [4:0] RES_NONE    = 5'd16;
  localparam logic [4:0] RES_INVALID = 5'd17;

  logic [3:0]       row_meta;
  logic [3:0]       row_sync;
  logic [DIV_W-1:0] div;
  logic [1:0]       col;
  logic [15:0]      snapshot;
  logic             eval_pending;
  logic [4:0]       candidate;
  logic [4:0]       stable;
  logic [CNT_W-1:0] cnt;

  logic [4:0]       ones;
  logic [3:0]       hot_idx;
  logic [4:0]       scan_result;
  logic [4:0]       cand_next;
  logic [CNT_W-1:0] cnt_next;
  logic             accept;
  logic [1:0]       col_next;

  assign col_next = col + 2'd1;

  always_comb begin
    ones        = '0;
    hot_idx     = '0;
    scan_result = RES_NONE;
    for (int i = 0; i < 16; i++) begin
      if (snapshot[i]) begin
        ones    = ones + 5'd1;
        hot_idx = 4'(i);
      end
    end
    if (ones == 5'd1)
      scan_result = {1'b0, hot_idx};
    else if (ones != 5'd0)
      scan_result = RES_INVALID;
  end

  // A result is accepted once it has repeated enough scans; INVALID never is.
  always_comb begin
    cand_next = candidate;
    cnt_next  = cnt;
    if (scan_result == candidate) begin
      if (cnt != CNT_MAX)
        cnt_next = cnt + CNT_ONE;
    end else begin
      cand_next = scan_result;
      cnt_next  = CNT_ONE;
    end
    accept = (cnt_next == CNT_MAX) && (cand_next != stable) &&
             (cand_next != RES_INVALID);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      row_meta     <= 4'hF;
      row_sync     <= 4'hF;
      div          <= '0;
      col          <= '0;
      col_out      <= 4'b1110;
      snapshot     <= '0;
      eval_pending <= 1'b0;
      candidate    <= RES_NONE;
      stable       <= RES_NONE;
      cnt          <= '0;
      key_code     <= '0;
      key_valid    <= 1'b0;
      key_held     <= 1'b0;
    end else begin
      row_meta     <= row_in;
      row_sync     <= row_meta;
      key_valid    <= 1'b0;
      eval_pending <= (div == DIV_LAST) && (col == 2'd3);

      if (div == DIV_LAST) begin
        div                      <= '0;
        col                      <= col_next;
        col_out                  <= ~(4'b0001 << col_next);
        snapshot[{col, 2'b00} +: 4] <= ~row_sync;
      end else begin
        div <= div + 1'b1;
      end

      // Evaluation falls in column 0's first cycle, never on a sample cycle.
      if (eval_pending) begin
        snapshot  <= '0;
        candidate <= cand_next;
        cnt       <= cnt_next;
        if (accept) begin
          stable <= cand_next;
          if (cand_next == RES_NONE) begin
            key_held <= 1'b0;
          end else begin
            key_code  <= cand_next[3:0];
            key_held  <= 1'b1;
            key_valid <= 1'b1;
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_keypad_scanner.sv
// Directed bench for keypad_scanner with a behavioural keypad (pressed-key mask
// gated by the driven column) and an expected-key-code queue for strobes.
module tb_keypad_scanner;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [3:0] row_in;
  logic [3:0] col_out;
  logic [3:0] key_code;
  logic       key_valid;
  logic       key_held;

  logic [15:0] pressed;
  logic        watch_held;
  logic        held_drop;
  int          pulse_cnt;
  int          run_len;
  int          max_run;
  int          n_checks;
  int          n_errors;
  logic [3:0]  exp_q[$];
  logic [3:0]  col_pat [4];

  keypad_scanner #(.SCAN_DIV(4), .DEBOUNCE_SCANS(2)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .row_in    (row_in),
    .col_out   (col_out),
    .key_code  (key_code),
    .key_valid (key_valid),
    .key_held  (key_held)
  );

  // ---------------- clock ----------------
  always #5 clk = ~clk;

  // A key pulls its row low only while its column is driven low.
  always_comb begin
    row_in = 4'hF;
    for (int c = 0; c < 4; c++)
      for (int r = 0; r < 4; r++)
        if (col_out[c] == 1'b0 && pressed[c*4+r]) row_in[r] = 1'b0;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)", tag, got, got, exp, exp);
    end
  endtask

  task automatic wait_cycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Leaves the bench at the first negedge of a fresh scan (column 0).
  task automatic wait_scan_start();
    int n = 0;
    while (col_out !== 4'b0111 && n < 80) begin @(negedge clk); n++; end
    while (col_out !== 4'b1110 && n < 80) begin @(negedge clk); n++; end
    if (n >= 80) check("scan_align_timeout", n, 0);
  endtask

  task automatic press_aligned(input logic [15:0] mask);
    wait_scan_start();
    pressed = mask;
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_col_out"}, col_out, 4'b1110);
    check({tag, "_key_code"}, key_code, 0);
    check({tag, "_key_valid"}, key_valid, 0);
    check({tag, "_key_held"}, key_held, 0);
  endtask

  // ---------------- scoreboard: strobe monitor ----------------
  always @(negedge clk) begin
    if (key_valid === 1'b1) begin
      run_len++;
      if (run_len > max_run) max_run = run_len;
      pulse_cnt++;
      if (exp_q.size() == 0) check("unexpected_pulse_code", key_code, 32'hFFFF);
      else                   check("pulse_code", key_code, exp_q.pop_front());
    end else begin
      run_len = 0;
    end
    if (watch_held && key_held !== 1'b1) held_drop = 1'b1;
  end

  // ---------------- stimulus ----------------
  initial begin
    col_pat    = '{4'b1110, 4'b1101, 4'b1011, 4'b0111};
    rst_n      = 1'b0;
    pressed    = '0;
    watch_held = 1'b0;
    held_drop  = 1'b0;
    pulse_cnt  = 0;
    run_len    = 0;
    max_run    = 0;
    n_checks   = 0;
    n_errors   = 0;

    repeat (2) @(posedge clk);
    @(negedge clk);
    check_reset_outputs("reset");
    rst_n = 1'b1;

    // Idle: four cycles per column through the whole rotation.
    for (int i = 1; i < 16; i++) begin
      @(negedge clk);
      check($sformatf("col_walk_%0d", i), col_out, col_pat[i/4]);
    end
    wait_cycles(32);
    check("idle_pulses", pulse_cnt, 0);
    check("idle_held", key_held, 0);
    check("idle_code", key_code, 0);

    // Key 6: column 1, row 2.
    exp_q.push_back(4'd6);
    press_aligned(16'h0040);
    wait_cycles(48);
    check("k6_pulses", pulse_cnt, 1);
    check("k6_code", key_code, 6);
    check("k6_held", key_held, 1);
    press_aligned(16'h0000);
    wait_cycles(48);
    check("k6_rel_held", key_held, 0);
    check("k6_rel_code", key_code, 6);
    check("k6_rel_pulses", pulse_cnt, 1);

    // Key 9 bouncing on alternate scans, then steady.
    wait_scan_start();
    for (int s = 0; s < 4; s++) begin
      pressed = (s % 2 == 0) ? 16'h0200 : 16'h0000;
      wait_cycles(16);
    end
    check("bounce_pulses", pulse_cnt, 1);
    check("bounce_held", key_held, 0);
    check("bounce_code", key_code, 6);
    exp_q.push_back(4'd9);
    pressed = 16'h0200;
    wait_cycles(48);
    check("k9_pulses", pulse_cnt, 2);
    check("k9_code", key_code, 9);
    check("k9_held", key_held, 1);
    press_aligned(16'h0000);
    wait_cycles(48);
    check("k9_rel_held", key_held, 0);

    // Keys 1 and 14 together: ghost/multi-press is never accepted.
    press_aligned(16'h4002);
    wait_cycles(64);
    check("multi_pulses", pulse_cnt, 2);
    check("multi_held", key_held, 0);
    check("multi_code", key_code, 9);
    press_aligned(16'h0000);
    wait_cycles(48);

    // Key 3, then straight to key 12 without release.
    exp_q.push_back(4'd3);
    press_aligned(16'h0008);
    wait_cycles(48);
    check("k3_pulses", pulse_cnt, 3);
    check("k3_code", key_code, 3);
    check("k3_held", key_held, 1);
    watch_held = 1'b1;
    exp_q.push_back(4'd12);
    press_aligned(16'h1000);
    wait_cycles(48);
    watch_held = 1'b0;
    check("k12_pulses", pulse_cnt, 4);
    check("k12_code", key_code, 12);
    check("k12_held", key_held, 1);
    check("k12_held_continuous", held_drop, 0);
    press_aligned(16'h0000);
    wait_cycles(48);
    check("k12_rel_held", key_held, 0);

    // Key 5 interrupted by reset during its second debounce scan.
    press_aligned(16'h0020);
    wait_cycles(24);
    rst_n = 1'b0;
    @(posedge clk);
    @(negedge clk);
    check_reset_outputs("midreset");
    rst_n = 1'b1;
    wait_cycles(20);
    check("k5_one_scan_pulses", pulse_cnt, 4);
    check("k5_one_scan_held", key_held, 0);
    exp_q.push_back(4'd5);
    wait_cycles(16);
    check("k5_pulses", pulse_cnt, 5);
    check("k5_code", key_code, 5);
    check("k5_held", key_held, 1);
    pressed = '0;
    wait_cycles(4);

    check("valid_width", max_run, 1);
    check("exp_q_drained", exp_q.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
